// File: rtl/ins_dec_seq.sv
// rtl/ins_dec_seq.sv - instruction register, field decode and per-class register-file phase sequencer
// Phase outputs are decoded from state and the instruction register; done in EXEC also follows ex_done.
module ins_dec_seq #(
  parameter int R      = 3,
  parameter int DATA_W = 16,
  localparam int W     = 3*R + 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in,
  input  logic              ex_done,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [2:0]        nsel,
  output logic [R-1:0]      readnum,
  output logic [R-1:0]      writenum,
  output logic              rd_en,
  output logic              wr_en,
  output logic              ex_en,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB, ILL} state_t;

  state_t         state;
  logic [W-1:0]   ir;
  logic [R-1:0]   rn, rd, rm;
  logic           is_movi, is_cmp;
  logic [R-1:0]   sel_idx;

  assign opcode = ir[W-1 -: 3];
  assign op     = ir[W-4 -: 2];
  assign ALUop  = op;
  assign rn     = ir[W-6 -: R];
  assign rd     = ir[2*R+1 -: R];
  assign shift  = ir[R+1 -: 2];
  assign rm     = ir[R-1:0];

  assign sximm5 = DATA_W'($signed(ir[R+1:0]));
  assign sximm8 = DATA_W'($signed(ir[2*R+1:0]));

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);

  assign in_ready = (state == IDLE) && !reset;

  // Entry phase chosen from the opcode/op bits of the incoming instruction.
  function automatic state_t first_phase(input logic [4:0] key);
    case (key)
      5'b110_10:                       return WB;
      5'b110_00, 5'b101_11:            return RD_B;
      5'b101_00, 5'b101_10, 5'b101_01: return RD_A;
      default:                         return ILL;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ir    <= in;
            state <= first_phase(in[W-1 -: 5]);
          end
        end
        RD_A:    state <= RD_B;
        RD_B:    state <= EXEC;
        EXEC: begin
          if (ex_done) state <= is_cmp ? IDLE : WB;
        end
        WB:      state <= IDLE;
        ILL:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    nsel    = 3'b000;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    ex_en   = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state)
      RD_A: begin
        nsel  = 3'b001;
        rd_en = 1'b1;
      end
      RD_B: begin
        nsel  = 3'b100;
        rd_en = 1'b1;
      end
      EXEC: begin
        ex_en = 1'b1;
        done  = is_cmp && ex_done;
      end
      WB: begin
        nsel  = is_movi ? 3'b001 : 3'b010;
        wr_en = 1'b1;
        done  = 1'b1;
      end
      ILL: begin
        illegal = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_idx = '0;
    case (nsel)
      3'b001:  sel_idx = rn;
      3'b010:  sel_idx = rd;
      3'b100:  sel_idx = rm;
      default: sel_idx = '0;
    endcase
  end

  assign readnum  = sel_idx;
  assign writenum = sel_idx;

endmodule

// File: tb/tb_ins_dec_seq.sv
// tb/tb_ins_dec_seq.sv - randomized check of ins_dec_seq against a phase-list reference model
module tb_ins_dec_seq;

  localparam int R  = 3;
  localparam int DW = 16;

  localparam int P_IDLE = 0;
  localparam int P_RDA  = 1;
  localparam int P_RDB  = 2;
  localparam int P_EXEC = 3;
  localparam int P_WB   = 4;
  localparam int P_ILL  = 5;

  typedef int iq_t[$];

  logic          clk = 1'b0;
  logic          reset, in_valid, ex_done, in_ready;
  logic [15:0]   in;
  logic [2:0]    opcode, nsel;
  logic [1:0]    op, ALUop, shift;
  logic [DW-1:0] sximm5, sximm8;
  logic [R-1:0]  readnum, writenum;
  logic          rd_en, wr_en, ex_en, done, illegal;

  int n_chk  = 0;
  int n_fail = 0;

  ins_dec_seq #(.R(R), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .ex_done(ex_done), .opcode(opcode), .op(op), .ALUop(ALUop), .shift(shift),
    .sximm5(sximm5), .sximm8(sximm8), .nsel(nsel), .readnum(readnum),
    .writenum(writenum), .rd_en(rd_en), .wr_en(wr_en), .ex_en(ex_en),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sext(input int v, input int bits);
    int x;
    x = v & ((1 << bits) - 1);
    if (x >= (1 << (bits - 1))) x = x - (1 << bits);
    return x & 16'hFFFF;
  endfunction

  function automatic iq_t phases_of(input logic [15:0] i);
    case (int'(i) >> 11)
      5'b110_10: return '{P_WB};
      5'b110_00: return '{P_RDB, P_EXEC, P_WB};
      5'b101_11: return '{P_RDB, P_EXEC, P_WB};
      5'b101_00: return '{P_RDA, P_RDB, P_EXEC, P_WB};
      5'b101_10: return '{P_RDA, P_RDB, P_EXEC, P_WB};
      5'b101_01: return '{P_RDA, P_RDB, P_EXEC};
      default:   return '{P_ILL};
    endcase
  endfunction

  // Expected {nsel, selected index, {rd_en,wr_en,ex_en,done,illegal}} for one phase.
  task automatic check_phase(input string tag, input logic [15:0] i, input int ph, input logic exd);
    int rn, rd, rm, ns, idx, ctl;
    bit movi, cmp;
    rn   = (int'(i) >> 8) & 7;
    rd   = (int'(i) >> 5) & 7;
    rm   = int'(i) & 7;
    movi = (int'(i) >> 11) == 5'b110_10;
    cmp  = (int'(i) >> 11) == 5'b101_01;
    ns = 0; idx = 0; ctl = 0;
    case (ph)
      P_RDA:  begin ns = 1; idx = rn; ctl = 5'b10000; end
      P_RDB:  begin ns = 4; idx = rm; ctl = 5'b10000; end
      P_EXEC: begin ctl = (cmp && exd) ? 5'b00110 : 5'b00100; end
      P_WB:   begin ns = movi ? 1 : 2; idx = movi ? rn : rd; ctl = 5'b01010; end
      P_ILL:  begin ctl = 5'b00011; end
      default: ;
    endcase
    check({tag, "_nsel"}, 32'(nsel), 32'(ns));
    check({tag, "_readnum"}, 32'(readnum), 32'(idx));
    check({tag, "_writenum"}, 32'(writenum), 32'(idx));
    check({tag, "_ctl"}, 32'({rd_en, wr_en, ex_en, done, illegal}), 32'(ctl));
  endtask

  task automatic check_fields(input string tag, input logic [15:0] i);
    check({tag, "_opcode"}, 32'(opcode), 32'(int'(i) >> 13));
    check({tag, "_op"}, 32'({ALUop, op}), 32'({2{2'((int'(i) >> 11) & 3)}}));
    check({tag, "_shift"}, 32'(shift), 32'((int'(i) >> 3) & 3));
    check({tag, "_sximm5"}, 32'(sximm5), 32'(sext(int'(i), 5)));
    check({tag, "_sximm8"}, 32'(sximm8), 32'(sext(int'(i), 8)));
  endtask

  // Accept one instruction from IDLE and follow it through every phase.
  task automatic run_instr(input logic [15:0] i, input int stall, input bit junk);
    iq_t ph;
    logic exd;
    @(negedge clk);
    check_phase("idle", 16'h0, P_IDLE, 1'b0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    in       = i;
    in_valid = 1'b1;
    ex_done  = 1'($urandom);
    @(posedge clk); #1;
    ph = phases_of(i);
    foreach (ph[k]) begin
      for (int s = 0; s <= ((ph[k] == P_EXEC) ? stall : 0); s++) begin
        exd      = (ph[k] == P_EXEC) ? (s == stall) : 1'($urandom);
        ex_done  = exd;
        in_valid = junk;
        in       = 16'($urandom);
        @(negedge clk);
        check_phase("phase", i, ph[k], exd);
        check_fields("busy", i);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    ex_done  = 1'b0;
  endtask

  logic [4:0] legal_keys [6] = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_10, 5'b101_01, 5'b101_11};

  initial begin
    logic [15:0] ri;
    reset    = 1'b1;
    in_valid = 1'b1;
    in       = 16'hD1FD;
    ex_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check_phase("rst", 16'h0, P_IDLE, 1'b0);
    check_fields("rst", 16'h0);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    check("rst_no_accept", 32'(opcode), 32'd0);

    run_instr(16'hD1FD, 0, 1'b0);
    check("movimm_sximm8", 32'(sximm8), 32'hFFFD);
    run_instr(16'hA148, 0, 1'b1);
    run_instr(16'hAB04, 3, 1'b1);
    run_instr(16'h0000, 0, 1'b0);
    check("ill_sximm5", 32'(sximm5), 32'h0000);
    run_instr(16'hD01F, 0, 1'b0);
    check("sx_imm5", 32'(sximm5), 32'hFFFF);
    check("sx_imm8", 32'(sximm8), 32'h001F);

    // Reset in the middle of an ADD's EXEC stall discards it.
    @(negedge clk);
    in = 16'hA148; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_exec", 32'(ex_en), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_phase("midrst", 16'h0, P_IDLE, 1'b0);
    check_fields("midrst", 16'h0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    ex_done = 1'b1;
    @(negedge clk);
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("midrst_no_wb", 32'(wr_en), 32'd0);
    end
    ex_done = 1'b0;

    for (int n = 0; n < 60; n++) begin
      ri = 16'($urandom);
      if ($urandom_range(3) != 0) ri[15:11] = legal_keys[$urandom_range(5)];
      run_instr(ri, int'($urandom_range(3)), 1'($urandom));
    end

    @(negedge clk);
    check_phase("final_idle", 16'h0, P_IDLE, 1'b0);
    check("final_in_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
